switch_debounce: RTL
====================

# switch_debounce

Input conditioning stage that sits directly upstream of the Avalon switch PIO: it takes raw, asynchronous, bouncing slide-switch/button pins, synchronises them into `clk`, and debounces them with a per-bit stability counter. Its clean `sw_level` output drives the PIO's `in_port`, so the PIO's level-sensitive IRQ (`data_in & irq_mask`) only fires on settled values. One-cycle edge pulses are also provided for hardware consumers that need events rather than levels.

## Interface
- `WIDTH`, 1: number of independent switch bits.
- `SYNC_STAGES`, 2: synchroniser flip-flop depth; legal ≥ 2.
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before accepting a change (10 ms at 50 MHz); legal ≥ 1.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sw_raw`  in  WIDTH  raw switch pins, asynchronous to `clk`.
- `sw_level`  out  WIDTH  debounced level, registered; feeds the PIO `in_port`.
- `sw_rise`  out  WIDTH  one-cycle pulse per bit on an accepted 0→1 change.
- `sw_fall`  out  WIDTH  one-cycle pulse per bit on an accepted 1→0 change.
- `sw_changed`  out  1  OR of all `sw_rise | sw_fall` bits, registered with them.

## Operation
- Each bit is handled fully independently: its own synchroniser chain, counter (`CNT_W = $clog2(DEBOUNCE_CYCLES+1)`), and FSM.
- FSM states per bit: `ST_LO`, `WAIT_HI`, `ST_HI`, `WAIT_LO`. `sync` is the last synchroniser stage.
  - `ST_LO`: `sync`=1 → `WAIT_HI`, `cnt`←0.
  - `WAIT_HI`: `sync`=0 → `ST_LO`, `cnt`←0, no output change. `sync`=1 and `cnt`==DEBOUNCE_CYCLES−1 → `ST_HI`, `sw_level`←1, `sw_rise`←1. Otherwise `cnt`←`cnt`+1.
  - `ST_HI` and `WAIT_LO` mirror the above with polarity inverted, producing `sw_fall`.
- In the stable states, `cnt` is held at 0.
- Pulses are registered, last exactly one cycle, and coincide with the first cycle of the new `sw_level` value.
- A bounce during a WAIT state fully restarts qualification. There is no partial credit and no pulse is generated.
- `cnt` never exceeds DEBOUNCE_CYCLES−1, so there is no wrap-around.
- Reset (any cycle, including mid-WAIT):
  - All synchroniser flops, `cnt`, `sw_level`, `sw_rise`, `sw_fall`, and `sw_changed` go to 0.
  - The FSM goes to `ST_LO`.
  - A pin held high through reset is re-qualified normally afterwards and produces one `sw_rise`.

## Timing
- If `sw_raw[i]` changes before clock edge E0 and stays stable, `sw_level[i]`/`sw_rise[i]` change on edge E0+SYNC_STAGES+DEBOUNCE_CYCLES. This is DEBOUNCE_CYCLES+1 consecutive FSM samples of the new value.
- Any reversal of `sync` seen by the FSM before that edge cancels the change.
- Minimum spacing between two accepted changes on one bit is DEBOUNCE_CYCLES+1 cycles.
- Changes on different bits in the same cycle produce simultaneous pulses. `sw_changed` is a single-cycle 1 in that case.
- All outputs are registered, with no combinational path from `sw_raw`.

## Structure
- Package `switch_pkg` holds:
  - the state typedef (`ST_LO`, `WAIT_HI`, `ST_HI`, `WAIT_LO`, 2-bit encoding);
  - the default `DEBOUNCE_CYCLES` constant (derived from a 50 MHz `CLK_HZ` constant and a 10 ms target).
- One sub-module, `debounce_cell`, contains the single-bit synchroniser, counter, and FSM, and has the same `clk`/`reset`.
- The top instantiates WIDTH cells in a generate loop and ORs their pulses into `sw_changed`.
- The synchroniser flops carry the team's standard synchroniser attribute.

## Test plan
Benches use WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.

1. Clean step: `sw_raw`=01 before edge 0, held → `sw_level`=01 and `sw_rise`=01, `sw_changed`=1 on edge 6 only; `sw_rise`=00 on edge 7.
2. Bounce: bit0 pattern 1,1,0,1,1,1,1,1 → no output until 5 consecutive FSM samples of 1; a single `sw_rise[0]` pulse, with none during the glitch.
3. Release: from `sw_level`=01, drive `sw_raw`=00 → `sw_fall`=01 for exactly one cycle, 6 edges later; `sw_level`=00 afterwards.
4. Simultaneous: bit0 1→0 and bit1 0→1 on the same edge → `sw_rise`=10 and `sw_fall`=01 on the same edge; `sw_changed` high for one cycle.
5. Reset mid-WAIT: assert `reset` for 1 cycle at `cnt`=2 while `sw_raw`=01 is held → all outputs 0 during reset; `sw_rise[0]` occurs 6 edges after `reset` deasserts.
6. Short pulse: a 4-cycle-wide high on `sw_raw[0]` → `sw_level` stays 0 and no pulses are generated.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and timing constants for the switch debounce block.
package switch_pkg;

    localparam int CLK_HZ                  = 50_000_000;
    localparam int DEBOUNCE_MS             = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } sw_state_t;

endpackage

// File: rtl/switch_debounce_if.sv
// Raw switch pins in, debounced level and edge events out.
interface switch_debounce_if #(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_level;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    modport master (
        output sw_raw,
        input  sw_level,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    modport slave (
        input  sw_raw,
        output sw_level,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );

endinterface

// File: rtl/debounce_cell.sv
// One switch bit: synchroniser chain, stability counter and four-state FSM.
module debounce_cell
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_changed_next
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

    sw_state_t        r_state;
    sw_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             w_level_next;
    logic             w_rise_next;
    logic             w_fall_next;
    logic             w_sync;
    logic             w_done;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_done = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_state <= ST_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
        end
    end

    // A reversal of the synchronised input in a WAIT state drops straight back.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LO:   if (w_sync)      w_state_next = WAIT_HI;
            WAIT_HI: if (!w_sync)     w_state_next = ST_LO;
                     else if (w_done) w_state_next = ST_HI;
            ST_HI:   if (!w_sync)     w_state_next = WAIT_LO;
            WAIT_LO: if (w_sync)      w_state_next = ST_HI;
                     else if (w_done) w_state_next = ST_LO;
            default:                  w_state_next = ST_LO;
        endcase
    end

    // Counter only advances while still qualifying; everything else zeroes it.
    always_comb begin
        w_cnt_next   = '0;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        w_level_next = r_level;
        case (r_state)
            WAIT_HI: begin
                if (w_sync && !w_done) w_cnt_next = r_cnt + CNT_W'(1);
                if (w_sync && w_done) begin
                    w_rise_next  = 1'b1;
                    w_level_next = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!w_sync && !w_done) w_cnt_next = r_cnt + CNT_W'(1);
                if (!w_sync && w_done) begin
                    w_fall_next  = 1'b1;
                    w_level_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign o_level        = r_level;
    assign o_rise         = r_rise;
    assign o_fall         = r_fall;
    assign o_changed_next = w_rise_next | w_fall_next;

endmodule

// File: rtl/switch_debounce.sv
// Per-bit debounce of raw switch pins, feeding the switch PIO in_port.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    switch_debounce_if.slave   bus
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_changed_next;
    logic             r_changed;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            debounce_cell #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cell (
                .clk            (clk),
                .reset          (reset),
                .i_raw          (bus.sw_raw[gi]),
                .o_level        (w_level[gi]),
                .o_rise         (w_rise[gi]),
                .o_fall         (w_fall[gi]),
                .o_changed_next (w_changed_next[gi])
            );
        end
    endgenerate

    // Built from the cells' next-pulse terms so it lands on the same edge as the pulses.
    always_ff @(posedge clk) begin
        if (reset) r_changed <= 1'b0;
        else       r_changed <= |w_changed_next;
    end

    assign bus.sw_level   = w_level;
    assign bus.sw_rise    = w_rise;
    assign bus.sw_fall    = w_fall;
    assign bus.sw_changed = r_changed;

endmodule
